serial_mag_comparator: RTL and testbench

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/comparator_pkg.sv | 29 ++
 rtl/serial_mag_comparator.sv | 105 ++++++++++
 tb/tb_serial_mag_comparator.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator:
// FSM state encoding and one-hot result codes.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int RES_EQ_BIT = 0;
    localparam int RES_LT_BIT = 1;
    localparam int RES_GT_BIT = 2;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b100;

    // Decide a differing bit pair; invert swaps polarity for a sign bit.
    function automatic logic [2:0] bit_result(
        input logic a_bit,
        input logic b_bit,
        input logic invert
    );
        return (invert ? b_bit : a_bit) ? RES_GT : RES_LT;
    endfunction

endpackage

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator, MSB first, early exit on the
// first differing bit pair; unsigned or two's-complement operands.
module serial_mag_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             a_gt_b
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [2:0]       res_q, res_d;

    logic a_bit;
    logic b_bit;
    logic at_msb;

    assign a_bit  = a_q[idx_q];
    assign b_bit  = b_q[idx_q];
    assign at_msb = (idx_q == MSB_IDX);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        res_d    = res_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    signed_d = signed_mode;
                    idx_d    = MSB_IDX;
                    state_d  = CMP;
                end
            end
            CMP: begin
                if (a_bit != b_bit) begin
                    state_d = DONE;
                    res_d   = bit_result(a_bit, b_bit, signed_q && at_msb);
                end else if (idx_q == '0) begin
                    state_d = DONE;
                    res_d   = RES_EQ;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    res_d   = RES_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                res_d   = RES_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    // Operands and index are only meaningful in CMP, so no reset.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        signed_q <= signed_d;
        idx_q    <= idx_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign a_eq_b    = res_q[RES_EQ_BIT];
    assign a_lt_b    = res_q[RES_LT_BIT];
    assign a_gt_b    = res_q[RES_GT_BIT];

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench: WIDTH=8 directed cases and WIDTH=3 exhaustive
// sweep with random out_ready, checked against a <,==,> model.
module tb_serial_mag_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst8 = 1'b1, iv8 = 1'b0, or8 = 1'b1, sm8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, eq8, lt8, gt8;

    logic       rst3 = 1'b1, iv3 = 1'b0, or3 = 1'b0, sm3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       ir3, ov3, eq3, lt3, gt3;

    serial_mag_comparator #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8),
        .out_ready(or8), .a_eq_b(eq8), .a_lt_b(lt8), .a_gt_b(gt8)
    );

    serial_mag_comparator #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst3), .in_valid(iv3), .in_ready(ir3),
        .a(a3), .b(b3), .signed_mode(sm3), .out_valid(ov3),
        .out_ready(or3), .a_eq_b(eq3), .a_lt_b(lt3), .a_gt_b(gt3)
    );

    typedef struct {
        logic [2:0] flags;
        int         lat;
        int         acc;
    } exp_t;

    exp_t q8[$];
    exp_t q3[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected flags as {gt, lt, eq}.
    function automatic logic [2:0] gold(input int w, input logic [7:0] a,
                                        input logic [7:0] b, input bit sm);
        longint av, bv;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        return {av > bv, av < bv, av == bv};
    endfunction

    function automatic int glat(input int w, input logic [7:0] a,
                                input logic [7:0] b);
        for (int k = w - 1; k >= 0; k--)
            if (a[k] !== b[k]) return w - k;
        return w;
    endfunction

    task automatic send8(input logic [7:0] a, input logic [7:0] b,
                         input bit sm, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!ir8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir8) begin
            chk("rdy8_timeout", 0, 1);
            return;
        end
        a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        if (push) q8.push_back('{gold(8, a, b, sm), glat(8, a, b), cyc});
    endtask

    task automatic send3(input logic [2:0] a, input logic [2:0] b,
                         input bit sm);
        int n;
        n = 0;
        @(negedge clk);
        while (!ir3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir3) begin
            chk("rdy3_timeout", 0, 1);
            return;
        end
        a3 = a; b3 = b; sm3 = sm; iv3 = 1'b1;
        @(posedge clk);
        #1 iv3 = 1'b0;
        q3.push_back('{gold(3, {5'b0, a}, {5'b0, b}, sm),
                       glat(3, {5'b0, a}, {5'b0, b}), cyc});
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while ((q8.size() != 0 || !ir8) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain8_timeout", n < 500, 1);
    endtask

    task automatic drain3();
        int n;
        n = 0;
        while ((q3.size() != 0 || !ir3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain3_timeout", n < 500, 1);
    endtask

    logic ov8_p = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst8) begin
            ov8_p = 1'b0;
        end else begin
            if (ov8 && !ov8_p) begin
                if (q8.size() == 0) begin
                    chk("unexpected8", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("res8", {gt8, lt8, eq8}, e.flags);
                    chk("lat8", cyc - e.acc, e.lat);
                end
            end
            if (!ov8) chk("idle_flags8", {gt8, lt8, eq8}, 3'b000);
            ov8_p = ov8;
        end
    end

    logic ov3_p = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst3) begin
            ov3_p = 1'b0;
        end else begin
            if (ov3 && !ov3_p) begin
                if (q3.size() == 0) begin
                    chk("unexpected3", 1, 0);
                end else begin
                    e = q3.pop_front();
                    chk("res3", {gt3, lt3, eq3}, e.flags);
                    chk("lat3", cyc - e.acc, e.lat);
                end
            end
            if (!ov3) chk("idle_flags3", {gt3, lt3, eq3}, 3'b000);
            ov3_p = ov3;
        end
    end

    always @(negedge clk) if (!rst3) or3 = 1'($urandom_range(0, 1));

    task automatic run8();
        int n;
        repeat (2) @(posedge clk);
        #1 rst8 = 1'b0;
        @(negedge clk);
        chk("rst_rdy8", ir8, 1);
        chk("rst_ov8", ov8, 0);
        chk("rst_flags8", {gt8, lt8, eq8}, 3'b000);

        send8(8'h80, 8'h7F, 1'b0, 1'b1);
        send8(8'h80, 8'h7F, 1'b1, 1'b1);
        send8(8'h5A, 8'h5A, 1'b0, 1'b1);
        send8(8'h03, 8'h02, 1'b0, 1'b1);
        send8(8'hFF, 8'h01, 1'b1, 1'b1);
        send8(8'h10, 8'h12, 1'b1, 1'b1);
        send8(8'h7F, 8'h80, 1'b1, 1'b1);
        drain8();

        or8 = 1'b0;
        send8(8'h11, 8'h22, 1'b0, 1'b1);
        n = 0;
        while (!ov8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait", ov8, 1);
        repeat (5) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; sm8 = 1'b0;
            chk("bp_ov", ov8, 1);
            chk("bp_rdy", ir8, 0);
            chk("bp_flags", {gt8, lt8, eq8}, 3'b010);
        end
        @(negedge clk);
        iv8 = 1'b0;
        or8 = 1'b1;
        chk("bp_hold_end", ov8, 1);
        @(posedge clk);
        #1 or8 = 1'b0;
        @(negedge clk);
        chk("bp_rel_ov", ov8, 0);
        chk("bp_rel_rdy", ir8, 1);
        chk("bp_rel_flags", {gt8, lt8, eq8}, 3'b000);
        or8 = 1'b1;
        send8(8'h40, 8'h40, 1'b1, 1'b1);
        drain8();

        send8(8'h01, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst8 = 1'b1;
        iv8 = 1'b1;
        a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk);
        #1 rst8 = 1'b0;
        iv8 = 1'b0;
        @(negedge clk);
        chk("midrst_rdy", ir8, 1);
        chk("midrst_ov", ov8, 0);
        chk("midrst_flags", {gt8, lt8, eq8}, 3'b000);
        send8(8'h01, 8'h00, 1'b0, 1'b1);
        drain8();
    endtask

    task automatic run3();
        repeat (2) @(posedge clk);
        #1 rst3 = 1'b0;
        @(negedge clk);
        chk("rst_rdy3", ir3, 1);
        chk("rst_ov3", ov3, 0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                for (int s = 0; s < 2; s++)
                    send3(3'(i), 3'(j), s[0]);
        drain3();
    endtask

    initial begin
        fork
            run8();
            run3();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
